// File: rtl/fft4_bin_streamer_if.sv
// Handshake and data bundle between the FFT core, the bin streamer and the
// downstream spectrum monitor.
interface fft4_bin_streamer_if #(
  parameter int W_IN  = 6,
  parameter int W_POW = 2 * W_IN
);
  // Frame capture side
  logic                   in_valid;
  logic                   in_ready;
  logic signed [W_IN-1:0] Ar, Br, Cr, Dr;
  logic signed [W_IN-1:0] Ai, Bi, Ci, Di;

  // Per-bin stream side
  logic                   out_valid;
  logic                   out_ready;
  logic [1:0]             out_bin;
  logic signed [W_IN-1:0] out_re;
  logic signed [W_IN-1:0] out_im;
  logic [W_POW-1:0]       out_pow;
  logic                   out_last;

  // Peak report
  logic                   peak_valid;
  logic [1:0]             peak_bin;
  logic [W_POW-1:0]       peak_pow;

  // Upstream/downstream environment driving the streamer
  modport master (
    output in_valid, Ar, Br, Cr, Dr, Ai, Bi, Ci, Di, out_ready,
    input  in_ready, out_valid, out_bin, out_re, out_im, out_pow, out_last,
    input  peak_valid, peak_bin, peak_pow
  );

  // The streamer itself
  modport slave (
    input  in_valid, Ar, Br, Cr, Dr, Ai, Bi, Ci, Di, out_ready,
    output in_ready, out_valid, out_bin, out_re, out_im, out_pow, out_last,
    output peak_valid, peak_bin, peak_pow
  );
endinterface

// File: rtl/fft4_bin_streamer.sv
// Captures one 4-bin FFT frame, streams the bins with their power one per
// transfer, then pulses a one-cycle report of the peak-power bin.
//
// state  | meaning
// IDLE   | waiting for a frame, in_ready high
// STREAM | presenting bin idx, advancing on each out transfer
// PEAK   | one cycle, peak_valid high with the frame's max-power bin
module fft4_bin_streamer #(
  parameter int W_IN  = 6,
  parameter int W_POW = 2 * W_IN
) (
  input logic                clk,
  input logic                rst,
  fft4_bin_streamer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    PEAK   = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             idx_q, idx_d;
  logic signed [W_IN-1:0] re_q [4];
  logic signed [W_IN-1:0] re_d [4];
  logic signed [W_IN-1:0] im_q [4];
  logic signed [W_IN-1:0] im_d [4];
  logic [W_POW-1:0]       max_pow_q, max_pow_d;
  logic [1:0]             max_bin_q, max_bin_d;
  logic [W_POW-1:0]       peak_pow_q, peak_pow_d;
  logic [1:0]             peak_bin_q, peak_bin_d;

  logic signed [W_IN-1:0]   cur_re, cur_im;
  logic signed [2*W_IN-1:0] re_x, im_x;
  logic signed [2*W_IN-1:0] re_sq, im_sq;
  logic [W_POW-1:0]         cur_pow;
  logic                     take_max;
  logic                     streaming;

  // Select the current bin and form its power; squares are never negative,
  // so reinterpreting them as unsigned before the add loses nothing.
  always_comb begin
    cur_re  = re_q[idx_q];
    cur_im  = im_q[idx_q];
    re_x    = (2*W_IN)'(cur_re);
    im_x    = (2*W_IN)'(cur_im);
    re_sq   = re_x * re_x;
    im_sq   = im_x * im_x;
    cur_pow = W_POW'($unsigned(re_sq)) + W_POW'($unsigned(im_sq));
  end

  // Next-state, capture and running-max logic.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    re_d       = re_q;
    im_d       = im_q;
    max_pow_d  = max_pow_q;
    max_bin_d  = max_bin_q;
    peak_pow_d = peak_pow_q;
    peak_bin_d = peak_bin_q;
    // Strict compare keeps the lower index on ties; bin 0 always seeds.
    take_max   = (idx_q == 2'd0) || (cur_pow > max_pow_q);
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          re_d[0]   = bus.Ar;
          re_d[1]   = bus.Br;
          re_d[2]   = bus.Cr;
          re_d[3]   = bus.Dr;
          im_d[0]   = bus.Ai;
          im_d[1]   = bus.Bi;
          im_d[2]   = bus.Ci;
          im_d[3]   = bus.Di;
          idx_d     = 2'd0;
          max_pow_d = '0;
          max_bin_d = 2'd0;
          state_d   = STREAM;
        end
      end
      STREAM: begin
        if (bus.out_ready) begin
          if (take_max) begin
            max_pow_d = cur_pow;
            max_bin_d = idx_q;
          end
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            // Latch the report now so it is visible throughout PEAK.
            peak_pow_d = max_pow_d;
            peak_bin_d = max_bin_d;
            state_d    = PEAK;
          end
        end
      end
      PEAK:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= 2'd0;
      max_pow_q  <= '0;
      max_bin_q  <= 2'd0;
      peak_pow_q <= '0;
      peak_bin_q <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        re_q[i] <= '0;
        im_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      max_pow_q  <= max_pow_d;
      max_bin_q  <= max_bin_d;
      peak_pow_q <= peak_pow_d;
      peak_bin_q <= peak_bin_d;
      re_q       <= re_d;
      im_q       <= im_d;
    end
  end

  // Stream fields read as zero whenever no bin is being offered.
  always_comb begin
    streaming      = (state_q == STREAM);
    bus.in_ready   = (state_q == IDLE);
    bus.out_valid  = streaming;
    bus.out_bin    = streaming ? idx_q : 2'd0;
    bus.out_re     = streaming ? cur_re : '0;
    bus.out_im     = streaming ? cur_im : '0;
    bus.out_pow    = streaming ? cur_pow : '0;
    bus.out_last   = streaming && (idx_q == 2'd3);
    bus.peak_valid = (state_q == PEAK);
    bus.peak_bin   = peak_bin_q;
    bus.peak_pow   = peak_pow_q;
  end

endmodule

// File: tb/tb_fft4_bin_streamer.sv
// Bench for fft4_bin_streamer: directed scenarios plus random frames, all
// compared against a plain-arithmetic model of bin power and peak choice.
module tb_fft4_bin_streamer;
  localparam int W_IN  = 6;
  localparam int W_POW = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft4_bin_streamer_if #(.W_IN(W_IN), .W_POW(W_POW)) bus ();
  fft4_bin_streamer #(.W_IN(W_IN), .W_POW(W_POW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Current frame and model expectations
  int fr_re[4];
  int fr_im[4];
  int exp_pow[4];
  int exp_pb, exp_pp;

  // Observations from one streamed frame
  int obs_bin[4], obs_re[4], obs_im[4], obs_pow[4], obs_last[4];
  int obs_n, peak_seen, obs_pb, obs_pp, first_valid;
  int hold_bad, inr_bad, pk_outv, pk_inr, post_pv, post_inr;
  int snap_bin, snap_re, snap_im, snap_pow;

  // Power of each bin and the first bin reaching the maximum.
  task automatic model();
    exp_pb = 0;
    exp_pp = -1;
    for (int b = 0; b < 4; b++) begin
      exp_pow[b] = fr_re[b] * fr_re[b] + fr_im[b] * fr_im[b];
      if (exp_pow[b] > exp_pp) begin
        exp_pp = exp_pow[b];
        exp_pb = b;
      end
    end
  endtask

  task automatic rand_frame();
    for (int b = 0; b < 4; b++) begin
      fr_re[b] = int'($urandom_range(0, 63)) - 32;
      fr_im[b] = int'($urandom_range(0, 63)) - 32;
    end
  endtask

  task automatic drive_frame();
    bus.Ar = fr_re[0][W_IN-1:0];
    bus.Br = fr_re[1][W_IN-1:0];
    bus.Cr = fr_re[2][W_IN-1:0];
    bus.Dr = fr_re[3][W_IN-1:0];
    bus.Ai = fr_im[0][W_IN-1:0];
    bus.Bi = fr_im[1][W_IN-1:0];
    bus.Ci = fr_im[2][W_IN-1:0];
    bus.Di = fr_im[3][W_IN-1:0];
    bus.in_valid = 1'b1;
  endtask

  // Called at a negedge while the block is idle; returns at the next negedge.
  task automatic start_frame(input bit hold);
    drive_frame();
    @(posedge clk);
    @(negedge clk);
    if (!hold) bus.in_valid = 1'b0;
  endtask

  // Records transfers and the peak pulse; returns at the negedge after PEAK
  // (or after the cycle budget expires with peak_seen still 0).
  task automatic collect(input int stall_bin, input int stall_len,
                         input bit rand_ready, input bit scramble);
    int cyc;
    int stalled;
    obs_n = 0; peak_seen = 0; hold_bad = 0; inr_bad = 0;
    pk_outv = -1; pk_inr = -1; obs_pb = -1; obs_pp = -1;
    snap_bin = -1; snap_re = -99; snap_im = -99; snap_pow = -1;
    stalled = 0; cyc = 0;
    first_valid = int'(bus.out_valid);
    for (int b = 0; b < 4; b++) begin
      obs_bin[b] = -1; obs_re[b] = -99; obs_im[b] = -99; obs_pow[b] = -1; obs_last[b] = -1;
    end
    while (!peak_seen && cyc < 100) begin
      if (scramble) begin
        bus.Ar = W_IN'($urandom); bus.Br = W_IN'($urandom);
        bus.Cr = W_IN'($urandom); bus.Dr = W_IN'($urandom);
        bus.Ai = W_IN'($urandom); bus.Bi = W_IN'($urandom);
        bus.Ci = W_IN'($urandom); bus.Di = W_IN'($urandom);
      end
      if (bus.out_valid && bus.in_ready) inr_bad++;
      if (bus.out_valid && int'(bus.out_bin) == stall_bin) begin
        if (stalled == 0) begin
          snap_bin = int'(bus.out_bin); snap_re = int'(bus.out_re);
          snap_im = int'(bus.out_im); snap_pow = int'(bus.out_pow);
        end else if (snap_re != int'(bus.out_re) || snap_im != int'(bus.out_im) ||
                     snap_pow != int'(bus.out_pow) || !bus.out_valid) begin
          hold_bad++;
        end
      end
      if (bus.out_valid && int'(bus.out_bin) == stall_bin && stalled < stall_len) begin
        stalled++;
        bus.out_ready = 1'b0;
      end else if (rand_ready) begin
        bus.out_ready = 1'($urandom_range(0, 1));
      end else begin
        bus.out_ready = 1'b1;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (obs_n < 4) begin
          obs_bin[obs_n]  = int'(bus.out_bin);
          obs_re[obs_n]   = int'(bus.out_re);
          obs_im[obs_n]   = int'(bus.out_im);
          obs_pow[obs_n]  = int'(bus.out_pow);
          obs_last[obs_n] = int'(bus.out_last);
        end
        obs_n++;
      end
      if (bus.peak_valid) begin
        peak_seen = 1;
        obs_pb = int'(bus.peak_bin);
        obs_pp = int'(bus.peak_pow);
        pk_outv = int'(bus.out_valid);
        pk_inr = int'(bus.in_ready);
      end
      cyc++;
      @(negedge clk);
    end
    post_pv = int'(bus.peak_valid);
    post_inr = int'(bus.in_ready);
  endtask

  task automatic test_reset();
    @(posedge clk);
    #2;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.peak_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: in_ready=%b out_valid=%b peak_valid=%b, want 1 0 0",
               bus.in_ready, bus.out_valid, bus.peak_valid);
    end
    checks++;
    if (bus.out_bin !== 2'd0 || bus.out_re !== '0 || bus.out_im !== '0 ||
        bus.out_pow !== '0 || bus.out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_stream: bin=%0d re=%0d im=%0d pow=%0d last=%b, want all 0",
               bus.out_bin, bus.out_re, bus.out_im, bus.out_pow, bus.out_last);
    end
    checks++;
    if (bus.peak_bin !== 2'd0 || bus.peak_pow !== '0) begin
      errors++;
      $display("FAIL reset_peak: peak_bin=%0d peak_pow=%0d, want 0 0", bus.peak_bin, bus.peak_pow);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int want_pow[4];
    want_pow = '{36, 8, 4, 8};
    fr_re = '{6, -2, -2, -2};
    fr_im = '{0, 2, 0, -2};
    start_frame(1'b0);
    collect(-1, 0, 1'b0, 1'b0);
    checks++;
    if (first_valid !== 1 || obs_n !== 4) begin
      errors++;
      $display("FAIL basic_latency: first_valid=%0d transfers=%0d, want 1 4", first_valid, obs_n);
    end
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (obs_bin[b] !== b || obs_re[b] !== fr_re[b] || obs_im[b] !== fr_im[b] ||
          obs_pow[b] !== want_pow[b] || obs_last[b] !== int'(b == 3)) begin
        errors++;
        $display("FAIL basic_bin%0d: got bin=%0d re=%0d im=%0d pow=%0d last=%0d, want %0d %0d %0d %0d %0d",
                 b, obs_bin[b], obs_re[b], obs_im[b], obs_pow[b], obs_last[b],
                 b, fr_re[b], fr_im[b], want_pow[b], int'(b == 3));
      end
    end
    checks++;
    if (peak_seen !== 1 || obs_pb !== 0 || obs_pp !== 36 || pk_outv !== 0 || pk_inr !== 0) begin
      errors++;
      $display("FAIL basic_peak: seen=%0d bin=%0d pow=%0d outv=%0d inr=%0d, want 1 0 36 0 0",
               peak_seen, obs_pb, obs_pp, pk_outv, pk_inr);
    end
    checks++;
    if (post_pv !== 0 || post_inr !== 1 || bus.peak_bin !== 2'd0 || bus.peak_pow !== 12'd36) begin
      errors++;
      $display("FAIL basic_after_peak: pv=%0d inr=%0d bin=%0d pow=%0d, want 0 1 0 36",
               post_pv, post_inr, bus.peak_bin, bus.peak_pow);
    end
  endtask

  task automatic test_backpressure();
    fr_re = '{6, -2, -2, -2};
    fr_im = '{0, 2, 0, -2};
    model();
    start_frame(1'b0);
    collect(1, 3, 1'b0, 1'b0);
    checks++;
    if (snap_bin !== 1 || snap_re !== -2 || snap_im !== 2 || snap_pow !== 8 ||
        hold_bad !== 0 || inr_bad !== 0) begin
      errors++;
      $display("FAIL bp_hold: bin=%0d re=%0d im=%0d pow=%0d unstable=%0d in_ready_hi=%0d, want 1 -2 2 8 0 0",
               snap_bin, snap_re, snap_im, snap_pow, hold_bad, inr_bad);
    end
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (obs_bin[b] !== b || obs_re[b] !== fr_re[b] || obs_im[b] !== fr_im[b] ||
          obs_pow[b] !== exp_pow[b] || obs_last[b] !== int'(b == 3)) begin
        errors++;
        $display("FAIL bp_bin%0d: got bin=%0d re=%0d im=%0d pow=%0d, want %0d %0d %0d %0d",
                 b, obs_bin[b], obs_re[b], obs_im[b], obs_pow[b], b, fr_re[b], fr_im[b], exp_pow[b]);
      end
    end
    checks++;
    if (peak_seen !== 1 || obs_pb !== exp_pb || obs_pp !== exp_pp) begin
      errors++;
      $display("FAIL bp_peak: seen=%0d bin=%0d pow=%0d, want 1 %0d %0d", peak_seen, obs_pb, obs_pp, exp_pb, exp_pp);
    end
  endtask

  task automatic test_extremes();
    fr_re = '{-32, -32, -32, -32};
    fr_im = '{-32, -32, -32, -32};
    start_frame(1'b0);
    collect(-1, 0, 1'b0, 1'b0);
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (obs_bin[b] !== b || obs_pow[b] !== 2048 || obs_re[b] !== -32 || obs_im[b] !== -32) begin
        errors++;
        $display("FAIL ext_bin%0d: got bin=%0d re=%0d im=%0d pow=%0d, want %0d -32 -32 2048",
                 b, obs_bin[b], obs_re[b], obs_im[b], obs_pow[b], b);
      end
    end
    checks++;
    if (peak_seen !== 1 || obs_pb !== 0 || obs_pp !== 2048) begin
      errors++;
      $display("FAIL ext_peak_tie: seen=%0d bin=%0d pow=%0d, want 1 0 2048", peak_seen, obs_pb, obs_pp);
    end
  endtask

  task automatic test_back_to_back();
    fr_re = '{1, 1, 1, -5};
    fr_im = '{0, 0, 0, 3};
    start_frame(1'b1);
    collect(-1, 0, 1'b0, 1'b0);
    checks++;
    if (obs_pow[0] !== 1 || obs_pow[1] !== 1 || obs_pow[2] !== 1 || obs_pow[3] !== 34 ||
        obs_pb !== 3 || obs_pp !== 34 || peak_seen !== 1) begin
      errors++;
      $display("FAIL b2b_frame1: pows=%0d,%0d,%0d,%0d peak=%0d/%0d seen=%0d, want 1,1,1,34 peak=3/34",
               obs_pow[0], obs_pow[1], obs_pow[2], obs_pow[3], obs_pb, obs_pp, peak_seen);
    end
    checks++;
    if (inr_bad !== 0 || pk_inr !== 0 || post_inr !== 1) begin
      errors++;
      $display("FAIL b2b_spacing: in_ready_during_stream=%0d in_peak=%0d after_peak=%0d, want 0 0 1",
               inr_bad, pk_inr, post_inr);
    end
    rand_frame();
    model();
    start_frame(1'b0);
    collect(-1, 0, 1'b0, 1'b0);
    checks++;
    if (first_valid !== 1) begin
      errors++;
      $display("FAIL b2b_accept: first_valid=%0d, want 1", first_valid);
    end
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (obs_bin[b] !== b || obs_re[b] !== fr_re[b] || obs_im[b] !== fr_im[b] || obs_pow[b] !== exp_pow[b]) begin
        errors++;
        $display("FAIL b2b_frame2_bin%0d: got bin=%0d re=%0d im=%0d pow=%0d, want %0d %0d %0d %0d",
                 b, obs_bin[b], obs_re[b], obs_im[b], obs_pow[b], b, fr_re[b], fr_im[b], exp_pow[b]);
      end
    end
    checks++;
    if (obs_pb !== exp_pb || obs_pp !== exp_pp) begin
      errors++;
      $display("FAIL b2b_frame2_peak: bin=%0d pow=%0d, want %0d %0d", obs_pb, obs_pp, exp_pb, exp_pp);
    end
  endtask

  task automatic test_reset_mid();
    int pv_seen;
    rand_frame();
    bus.out_ready = 1'b1;
    start_frame(1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_bin !== 2'd2) begin
      errors++;
      $display("FAIL rstmid_pre: out_valid=%b out_bin=%0d, want 1 2", bus.out_valid, bus.out_bin);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.peak_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_async: out_valid=%b peak_valid=%b in_ready=%b, want 0 0 1",
               bus.out_valid, bus.peak_valid, bus.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    pv_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.peak_valid || bus.out_valid) pv_seen++;
    end
    checks++;
    if (pv_seen !== 0) begin
      errors++;
      $display("FAIL rstmid_no_partial: active_cycles=%0d, want 0", pv_seen);
    end
    rand_frame();
    model();
    start_frame(1'b0);
    collect(-1, 0, 1'b0, 1'b0);
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (obs_bin[b] !== b || obs_re[b] !== fr_re[b] || obs_im[b] !== fr_im[b] || obs_pow[b] !== exp_pow[b]) begin
        errors++;
        $display("FAIL rstmid_fresh_bin%0d: got bin=%0d re=%0d im=%0d pow=%0d, want %0d %0d %0d %0d",
                 b, obs_bin[b], obs_re[b], obs_im[b], obs_pow[b], b, fr_re[b], fr_im[b], exp_pow[b]);
      end
    end
    checks++;
    if (peak_seen !== 1 || obs_pb !== exp_pb || obs_pp !== exp_pp) begin
      errors++;
      $display("FAIL rstmid_fresh_peak: seen=%0d bin=%0d pow=%0d, want 1 %0d %0d",
               peak_seen, obs_pb, obs_pp, exp_pb, exp_pp);
    end
  endtask

  // Random frames; optionally random backpressure and input scrambling.
  task automatic test_random(input string name, input int frames, input bit rand_ready, input bit scramble);
    for (int f = 0; f < frames; f++) begin
      rand_frame();
      model();
      start_frame(1'b0);
      collect(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), rand_ready, scramble);
      for (int b = 0; b < 4; b++) begin
        checks++;
        if (obs_bin[b] !== b || obs_re[b] !== fr_re[b] || obs_im[b] !== fr_im[b] ||
            obs_pow[b] !== exp_pow[b] || obs_last[b] !== int'(b == 3)) begin
          errors++;
          $display("FAIL %s_f%0d_bin%0d: got bin=%0d re=%0d im=%0d pow=%0d last=%0d, want %0d %0d %0d %0d %0d",
                   name, f, b, obs_bin[b], obs_re[b], obs_im[b], obs_pow[b], obs_last[b],
                   b, fr_re[b], fr_im[b], exp_pow[b], int'(b == 3));
        end
      end
      checks++;
      if (peak_seen !== 1 || obs_pb !== exp_pb || obs_pp !== exp_pp || hold_bad !== 0 || inr_bad !== 0) begin
        errors++;
        $display("FAIL %s_f%0d_peak: seen=%0d bin=%0d pow=%0d unstable=%0d inr=%0d, want 1 %0d %0d 0 0",
                 name, f, peak_seen, obs_pb, obs_pp, hold_bad, inr_bad, exp_pb, exp_pp);
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.Ar = '0; bus.Br = '0; bus.Cr = '0; bus.Dr = '0;
    bus.Ai = '0; bus.Bi = '0; bus.Ci = '0; bus.Di = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_extremes();
    test_back_to_back();
    test_reset_mid();
    test_random("chg", 4, 1'b0, 1'b1);
    test_random("rnd", 20, 1'b1, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft4_bin_streamer.md
Name: fft4_bin_streamer

Overview:
Downstream consumer of the 4-point FFT core. Captures one frame of eight signed bin components (Ar..Dr real, Ai..Di imaginary) under a valid/ready handshake. Streams the four bins out one per transfer with each bin's power (re^2 + im^2). After the last bin it reports the peak-power bin, for the spectrum monitor / detection logic.

Parameters:
W_IN, 6, width of each signed real/imag component from the FFT core
W_POW, 2*W_IN, width of unsigned power result (must hold 2*(2^(W_IN-1))^2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  FFT frame on Ar..Di is valid
in_ready  output  1  block can accept a frame
Ar, Br, Cr, Dr  input  W_IN each  signed real parts of bins 0..3
Ai, Bi, Ci, Di  input  W_IN each  signed imaginary parts of bins 0..3
out_valid  output  1  out_* fields hold a valid bin
out_ready  input  1  downstream accepts current bin
out_bin  output  2  bin index 0..3
out_re  output  W_IN  signed real part of current bin
out_im  output  W_IN  signed imaginary part of current bin
out_pow  output  W_POW  unsigned re^2 + im^2 of current bin
out_last  output  1  current bin is bin 3
peak_valid  output  1  one-cycle pulse; peak_bin/peak_pow valid
peak_bin  output  2  index of max-power bin of last frame
peak_pow  output  W_POW  power of that bin

Behaviour:
- Reset (async, immediate): state=IDLE; in_ready=1; out_valid=0, out_bin=0, out_re=0, out_im=0, out_pow=0, out_last=0; peak_valid=0, peak_bin=0, peak_pow=0; capture registers and running max cleared.
- States: IDLE, STREAM, PEAK.
- IDLE: in_ready=1, out_valid=0. On in_valid&in_ready at a clock edge: register all eight components, idx=0, running max cleared, go STREAM. Components are sampled only on that edge; later input changes are ignored.
- STREAM: in_ready=0, out_valid=1. out_bin=idx; out_re/out_im come from the capture registers selected by idx. out_pow = re*re + im*im, both signed products, combinational from registered values. out_pow has zero added latency relative to out_bin. out_last = (idx==3).
- Frame latency: first bin valid the cycle after the frame handshake.
- Transfer = out_valid & out_ready. With out_ready low, every out_* field holds stable and idx does not advance.
- On transfer: if out_pow > running max, or idx==0, update running max (pow, bin). Ties keep the lower index. idx increments.
- The transfer with idx==3 goes to PEAK.
- PEAK (exactly one cycle): peak_valid=1; peak_bin/peak_pow = final running max; out_valid=0; in_ready=0. Next cycle: IDLE.
- peak_bin/peak_pow hold their values until the next PEAK or reset. peak_valid is 1 only in PEAK.
- Back-to-back frames: minimum spacing is 6 cycles (handshake, 4 transfers, PEAK). The next frame can be accepted in the cycle after PEAK.
- Width rule: power is computed at full W_POW precision, with no saturation or truncation. (-32)^2+(-32)^2 = 2048 fits in 12 bits.
- Reset asserted mid-STREAM or in PEAK aborts the frame. No partial peak is reported.

Test Plan:
- Reset then frame Ar=6,Ai=0, Br=-2,Bi=2, Cr=-2,Ci=0, Dr=-2,Di=-2, out_ready=1 -> bins 0..3 on consecutive cycles with out_pow 36,8,4,8; out_last on bin 3; next cycle peak_valid=1, peak_bin=0, peak_pow=36.
- Backpressure: same frame, out_ready low 3 cycles during bin 1 -> out_bin=1, out_re=-2, out_im=2, out_pow=8 held stable; in_ready=0 throughout; sequence resumes unchanged.
- Extremes/tie: all components -32 -> every out_pow=2048 (12'h800); peak_bin=0 (tie goes to lowest index), peak_pow=2048.
- Peak at end: Ar..Cr=1, Ai..Ci=0, Dr=-5, Di=3 -> pows 1,1,1,34; peak_bin=3, peak_pow=34; in_valid held high across the frame -> second frame accepted only in the cycle after PEAK.
- Reset mid-stream: assert rst during bin 2 -> out_valid and peak_valid drop immediately, in_ready=1. A fresh frame afterwards streams from bin 0 with correct peak.
- Input change after capture: alter Ar..Di while in STREAM -> streamed values still match the captured frame.
